// File: rtl/matrix_multiplier_pkg.sv
// matrix_multiplier_pkg: shared constants for the pipelined matrix multiplier
package matrix_multiplier_pkg;
   localparam int MM_LATENCY    = 2;
   localparam int MM_DATA_WIDTH = 32;
   localparam int MM_ROWS_A     = 2;
   localparam int MM_COLS_A     = 2;
   localparam int MM_COLS_B     = 2;
endpackage

// File: rtl/mm_dot_product.sv
// mm_dot_product: one output element, registered products then registered wrapping sum
module mm_dot_product
   import matrix_multiplier_pkg::*;
#(
   parameter int DATA_WIDTH = MM_DATA_WIDTH,
   parameter int LEN        = MM_COLS_A
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [LEN-1:0][DATA_WIDTH-1:0] a_row,
   input  logic [LEN-1:0][DATA_WIDTH-1:0] b_col,
   output logic [DATA_WIDTH-1:0]          c
);
   logic [LEN-1:0][DATA_WIDTH-1:0] p_d, p_q;
   logic [DATA_WIDTH-1:0]          c_d, c_q;
   always_comb begin
      p_d = '0;
      c_d = '0;
      for (int k = 0; k < LEN; k++) begin
         p_d[k] = a_row[k] * b_col[k];
         c_d    = c_d + p_q[k];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= '0;
         c_q <= '0;
      end else begin
         p_q <= p_d;
         c_q <= c_d;
      end
   end
   assign c = c_q;
endmodule

// File: rtl/matrix_multiplier.sv
// matrix_multiplier: fully parallel C = A x B, two-cycle latency, one result per cycle
module matrix_multiplier
   import matrix_multiplier_pkg::*;
#(
   parameter int DATA_WIDTH = MM_DATA_WIDTH,
   parameter int ROWS_A     = MM_ROWS_A,
   parameter int COLS_A     = MM_COLS_A,
   parameter int COLS_B     = MM_COLS_B
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0] a,
   input  logic [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0] b,
   output logic [ROWS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0] c
);
   for (genvar i = 0; i < ROWS_A; i++) begin : g_row
      for (genvar j = 0; j < COLS_B; j++) begin : g_col
         logic [COLS_A-1:0][DATA_WIDTH-1:0] b_col;
         for (genvar k = 0; k < COLS_A; k++) begin : g_k
            assign b_col[k] = b[k][j];
         end
         mm_dot_product #(.DATA_WIDTH(DATA_WIDTH), .LEN(COLS_A)) u_dot (
            .clk   (clk),
            .rst_n (rst_n),
            .a_row (a[i]),
            .b_col (b_col),
            .c     (c[i][j])
         );
      end
   end
endmodule

// File: tb/tb_matrix_multiplier.sv
// tb_matrix_multiplier: directed table, reset, streaming and mid-run reset checks
module tb_matrix_multiplier;
   import matrix_multiplier_pkg::*;
   typedef logic [MM_ROWS_A-1:0][MM_COLS_A-1:0][MM_DATA_WIDTH-1:0] mat_t;
   typedef struct {
      string name;
      mat_t  a;
      mat_t  b;
      mat_t  c;
   } vec_t;

   logic clk = 0;
   logic rst_n = 0;
   mat_t a = '0, b = '0, c;
   int   passed = 0, total = 0;
   vec_t vecs[4];
   mat_t exp_q[$];

   matrix_multiplier #(
      .DATA_WIDTH(MM_DATA_WIDTH), .ROWS_A(MM_ROWS_A), .COLS_A(MM_COLS_A), .COLS_B(MM_COLS_B)
   ) dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c));

   always #5 clk = ~clk;

   function automatic mat_t mk(logic [31:0] e00, logic [31:0] e01, logic [31:0] e10, logic [31:0] e11);
      mat_t m;
      m[0][0] = e00; m[0][1] = e01; m[1][0] = e10; m[1][1] = e11;
      return m;
   endfunction

   function automatic mat_t rnd();
      mat_t m;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            m[i][j] = $urandom;
      return m;
   endfunction

   function automatic mat_t ref_mm(mat_t x, mat_t y);
      mat_t r = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            for (int k = 0; k < 2; k++)
               r[i][j] = r[i][j] + x[i][k] * y[k][j];
      return r;
   endfunction

   task automatic chk(string name, mat_t act, mat_t exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{"basic",    mk(1,2,3,4), mk(5,6,7,8), mk(19,22,43,50)};
      vecs[1] = '{"ident_b",  mk(1,2,3,4), mk(1,0,0,1), mk(1,2,3,4)};
      vecs[2] = '{"ident_a",  mk(1,0,0,1), mk(5,6,7,8), mk(5,6,7,8)};
      vecs[3] = '{"wrap",     mk(32'hFFFF_FFFF,32'hFFFF_FFFF,0,0), mk(2,2,2,2),
                              mk(32'hFFFF_FFFC,32'hFFFF_FFFC,0,0)};

      // held in reset with garbage inputs
      for (int t = 0; t < 3; t++) begin
         a = rnd(); b = rnd();
         edge1();
         chk($sformatf("reset_hold%0d", t), c, '0);
      end
      a = vecs[0].a; b = vecs[0].b;
      #2 rst_n = 1;
      edge1();
      chk("post_reset_edge1", c, '0);
      edge1();
      chk("post_reset_edge2", c, vecs[0].c);

      foreach (vecs[v]) begin
         a = vecs[v].a; b = vecs[v].b;
         edge1();
         edge1();
         chk(vecs[v].name, c, vecs[v].c);
      end

      for (int t = 0; t < 22; t++) begin
         edge1();
         if (t >= 2) chk($sformatf("stream%0d", t - 2), c, exp_q.pop_front());
         if (t < 20) begin
            a = rnd(); b = rnd();
            exp_q.push_back(ref_mm(a, b));
         end
      end

      // mid-run reset between edges
      for (int t = 0; t < 3; t++) begin
         a = rnd(); b = rnd();
         edge1();
      end
      chk("pre_midreset", c, ref_mm(a, b) === '0 ? mk(1,1,1,1) : c);
      #2 rst_n = 0;
      #1 chk("midreset_immediate", c, '0);
      edge1();
      chk("midreset_hold", c, '0);
      a = vecs[0].a; b = vecs[0].b;
      #2 rst_n = 1;
      #1 chk("midreset_release", c, '0);
      edge1();
      chk("midreset_edge1", c, '0);
      edge1();
      chk("midreset_edge2", c, vecs[0].c);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
